// File: rtl/xbar_pkg.sv
// Shared AXI crossbar definitions: response codes and the default-slave FSM state types.
package xbar_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i and holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/xbar_default_slave.sv
// AXI responder for unmapped addresses: every burst completes with DECERR, no data stored.
// Define DEFAULT_SLAVE_ERR_CNT_EN to build the saturating completed-transaction counters.
module xbar_default_slave
  import xbar_pkg::*;
#(
  parameter int IDS_WIDTH  = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [IDS_WIDTH-1:0]  ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [LEN_WIDTH-1:0]  ARLEN,
  input  logic [SIZE_WIDTH-1:0] ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [IDS_WIDTH-1:0]  RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic [IDS_WIDTH-1:0]  AWID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [LEN_WIDTH-1:0]  AWLEN,
  input  logic [SIZE_WIDTH-1:0] AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [IDS_WIDTH-1:0]  BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [15:0]           rd_err_cnt,
  output logic [15:0]           wr_err_cnt
);

  rd_state_t            rd_state_q, rd_state_d;
  wr_state_t            wr_state_q, wr_state_d;
  logic [IDS_WIDTH-1:0] rid_q, rid_d;
  logic [LEN_WIDTH-1:0] rlen_q, rlen_d;
  logic [LEN_WIDTH-1:0] rbeat_q, rbeat_d;
  logic [IDS_WIDTH-1:0] bid_q, bid_d;
  logic                 rdy_en_q;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // Address/data payload is irrelevant to an error responder.
  logic unused_inputs;
  assign unused_inputs = ^{ARADDR, ARSIZE, ARBURST, AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB};

  assign ARREADY = (rd_state_q == R_IDLE) && rdy_en_q;
  assign RVALID  = (rd_state_q == R_DATA);
  assign RLAST   = RVALID && (rbeat_q == rlen_q);
  assign RID     = rid_q;
  assign RDATA   = '0;
  assign RRESP   = RESP_DECERR;

  assign AWREADY = (wr_state_q == W_IDLE) && rdy_en_q;
  assign WREADY  = (wr_state_q == W_DATA);
  assign BVALID  = (wr_state_q == W_RESP);
  assign BID     = bid_q;
  assign BRESP   = RESP_DECERR;

  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;

  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    rlen_d     = rlen_q;
    rbeat_d    = rbeat_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rid_d      = ARID;
          rlen_d     = ARLEN;
          rbeat_d    = '0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (RLAST) begin
            rd_state_d = R_IDLE;
          end else begin
            rbeat_d = rbeat_q + 1'b1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write length is ignored; WLAST alone ends the burst.
  always_comb begin
    wr_state_d = wr_state_q;
    bid_d      = bid_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          bid_d      = AWID;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs && WLAST) begin
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rid_q      <= '0;
      rlen_q     <= '0;
      rbeat_q    <= '0;
      bid_q      <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rid_q      <= rid_d;
      rlen_q     <= rlen_d;
      rbeat_q    <= rbeat_d;
      bid_q      <= bid_d;
      rdy_en_q   <= 1'b1;
    end
  end

`ifdef DEFAULT_SLAVE_ERR_CNT_EN
  sat_counter #(
    .WIDTH(16)
  ) u_rd_cnt (
    .clk_i  (ACLK),
    .rst_ni (ARESETn),
    .inc_i  (r_hs && RLAST),
    .count_o(rd_err_cnt)
  );

  sat_counter #(
    .WIDTH(16)
  ) u_wr_cnt (
    .clk_i  (ACLK),
    .rst_ni (ARESETn),
    .inc_i  (b_hs),
    .count_o(wr_err_cnt)
  );
`else
  assign rd_err_cnt = 16'd0;
  assign wr_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_xbar_default_slave.sv
// Randomized self-checking bench for xbar_default_slave; model tracks beats, IDs and completions.
module tb_xbar_default_slave;

`ifdef DEFAULT_SLAVE_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [4:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [4:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic [4:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [4:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [15:0] rd_err_cnt;
  logic [15:0] wr_err_cnt;

  int errors = 0;
  int checks = 0;
  int rd_done = 0;
  int wr_done = 0;

  always #5 ACLK = ~ACLK;

  xbar_default_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .rd_err_cnt(rd_err_cnt), .wr_err_cnt(wr_err_cnt)
  );

  task automatic tick();
    @(negedge ACLK);
  endtask

  // One read burst; the model is simply "len+1 beats of DECERR with this ID, last on the final one".
  task automatic run_read(input logic [4:0] id, input logic [3:0] len, input int stall_pct);
    int budget;
    int beat;
    budget = 0;
    while (ARREADY !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    checks++;
    if (ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL ar_ready_wait got=%b exp=1", ARREADY);
    end
    ARID = id; ARLEN = len; ARADDR = $urandom; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    beat = 0;
    budget = 0;
    while (beat <= int'(len) && budget < 200) begin
      RREADY = ($urandom_range(0, 99) >= stall_pct);
      checks++;
      if (RVALID !== 1'b1 || RID !== id || RDATA !== 32'd0 || RRESP !== 2'b11 ||
          RLAST !== (beat == int'(len)) || ARREADY !== 1'b0) begin
        errors++;
        $display("FAIL rd_beat beat=%0d got v=%b id=%h d=%h resp=%b last=%b arrdy=%b exp v=1 id=%h d=0 resp=11 last=%b arrdy=0",
                 beat, RVALID, RID, RDATA, RRESP, RLAST, ARREADY, id, (beat == int'(len)));
      end
      if (RREADY) beat++;
      tick();
      budget++;
    end
    RREADY = 1'b0;
    checks++;
    if (beat != int'(len) + 1) begin
      errors++;
      $display("FAIL rd_beat_count got=%0d exp=%0d", beat, int'(len) + 1);
    end
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL rd_complete got rvalid=%b arready=%b exp rvalid=0 arready=1", RVALID, ARREADY);
    end
    rd_done++;
    $display("read  id=%h len=%0d beats=%0d cycles=%0d", id, len, beat, budget);
  endtask

  // One write burst of nbeats W beats; response is expected the cycle after the WLAST handshake.
  task automatic run_write(input logic [4:0] id, input int nbeats, input int stall_pct);
    int budget;
    int beat;
    bit done;
    budget = 0;
    while (AWREADY !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    AWID = id; AWADDR = $urandom; AWLEN = 4'($urandom_range(0, 15)); AWSIZE = 3'd2; AWBURST = 2'b01;
    AWVALID = 1'b1;
    checks++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b0) begin
      errors++;
      $display("FAIL aw_accept got awready=%b wready=%b exp awready=1 wready=0", AWREADY, WREADY);
    end
    tick();
    AWVALID = 1'b0;
    beat = 0;
    budget = 0;
    while (beat < nbeats && budget < 200) begin
      WVALID = ($urandom_range(0, 99) >= stall_pct);
      WLAST = (beat == nbeats - 1);
      WDATA = $urandom;
      WSTRB = 4'($urandom);
      checks++;
      if (WREADY !== 1'b1 || BVALID !== 1'b0 || AWREADY !== 1'b0) begin
        errors++;
        $display("FAIL wr_beat beat=%0d got wready=%b bvalid=%b awready=%b exp 1/0/0", beat, WREADY, BVALID, AWREADY);
      end
      if (WVALID) beat++;
      tick();
      budget++;
    end
    WVALID = 1'b0;
    WLAST = 1'b0;
    done = 1'b0;
    budget = 0;
    while (!done && budget < 200) begin
      BREADY = ($urandom_range(0, 99) >= stall_pct);
      checks++;
      if (BVALID !== 1'b1 || BID !== id || BRESP !== 2'b11 || WREADY !== 1'b0) begin
        errors++;
        $display("FAIL wr_resp got bvalid=%b bid=%h bresp=%b wready=%b exp bvalid=1 bid=%h bresp=11 wready=0",
                 BVALID, BID, BRESP, WREADY, id);
      end
      if (BREADY) done = 1'b1;
      tick();
      budget++;
    end
    BREADY = 1'b0;
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1 || !done) begin
      errors++;
      $display("FAIL wr_complete got bvalid=%b awready=%b done=%b exp 0/1/1", BVALID, AWREADY, done);
    end
    wr_done++;
    $display("write id=%h beats=%0d", id, nbeats);
  endtask

  task automatic test_reset();
    ARESETn = 1'b1;
    #2;
    ARESETn = 1'b0;
    tick();
    tick();
    checks++;
    if (ARREADY !== 1'b0 || AWREADY !== 1'b0 || WREADY !== 1'b0 || RVALID !== 1'b0 ||
        BVALID !== 1'b0 || RID !== 5'd0 || BID !== 5'd0 || RLAST !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got arr=%b awr=%b wr=%b rv=%b bv=%b rid=%h bid=%h rlast=%b exp all 0",
               ARREADY, AWREADY, WREADY, RVALID, BVALID, RID, BID, RLAST);
    end
    checks++;
    if (rd_err_cnt !== 16'd0 || wr_err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters got rd=%0d wr=%0d exp 0 0", rd_err_cnt, wr_err_cnt);
    end
    ARESETn = 1'b1;
    #1;
    checks++;
    if (ARREADY !== 1'b0 || AWREADY !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release got arr=%b awr=%b exp 0 0", ARREADY, AWREADY);
    end
    tick();
    checks++;
    if (ARREADY !== 1'b1 || AWREADY !== 1'b1) begin
      errors++;
      $display("FAIL ready_enable got arr=%b awr=%b exp 1 1", ARREADY, AWREADY);
    end
    $display("reset released");
  endtask

  task automatic test_read_burst();
    run_read(5'h13, 4'd3, 0);
  endtask

  task automatic test_read_stall();
    ARID = 5'h0A; ARLEN = 4'd0; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    RREADY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) RREADY = 1'b1;
      checks++;
      if (RVALID !== 1'b1 || RLAST !== 1'b1 || RID !== 5'h0A || RDATA !== 32'd0 || RRESP !== 2'b11) begin
        errors++;
        $display("FAIL rd_stall cyc=%0d got v=%b last=%b id=%h d=%h resp=%b exp v=1 last=1 id=0a d=0 resp=11",
                 i, RVALID, RLAST, RID, RDATA, RRESP);
      end
      tick();
    end
    RREADY = 1'b0;
    checks++;
    if (RVALID !== 1'b0) begin
      errors++;
      $display("FAIL rd_stall_done got rvalid=%b exp 0", RVALID);
    end
    rd_done++;
    $display("read  id=0a len=0 stalled 5 cycles");
  endtask

  task automatic test_write();
    run_write(5'h02, 2, 0);
  endtask

  task automatic test_w_before_aw();
    WVALID = 1'b1; WLAST = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (WREADY !== 1'b0) begin
        errors++;
        $display("FAIL w_before_aw cyc=%0d got wready=%b exp 0", i, WREADY);
      end
      tick();
    end
    ARID = 5'h07; ARLEN = 4'd0; ARVALID = 1'b1;
    AWID = 5'h19; AWLEN = 4'd0; AWVALID = 1'b1;
    checks++;
    if (ARREADY !== 1'b1 || AWREADY !== 1'b1) begin
      errors++;
      $display("FAIL dual_accept got arr=%b awr=%b exp 1 1", ARREADY, AWREADY);
    end
    tick();
    ARVALID = 1'b0; AWVALID = 1'b0; RREADY = 1'b1;
    checks++;
    if (RVALID !== 1'b1 || RID !== 5'h07 || RLAST !== 1'b1 || WREADY !== 1'b1) begin
      errors++;
      $display("FAIL dual_active got rv=%b rid=%h rlast=%b wready=%b exp 1 07 1 1", RVALID, RID, RLAST, WREADY);
    end
    tick();
    WVALID = 1'b0; WLAST = 1'b0; RREADY = 1'b0;
    checks++;
    if (RVALID !== 1'b0 || BVALID !== 1'b1 || BID !== 5'h19 || BRESP !== 2'b11) begin
      errors++;
      $display("FAIL dual_resp got rv=%b bv=%b bid=%h bresp=%b exp 0 1 19 11", RVALID, BVALID, BID, BRESP);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++;
      $display("FAIL dual_b_done got bvalid=%b exp 0", BVALID);
    end
    rd_done++;
    wr_done++;
    $display("dual  rid=07 bid=19 with early W beat");
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 0)
        run_read(5'($urandom), 4'($urandom_range(0, 7)), 30);
      else
        run_write(5'($urandom), int'($urandom_range(1, 4)), 30);
    end
  endtask

  task automatic test_counters();
    int exp_rd;
    int exp_wr;
    exp_rd = CNT_EN ? rd_done : 0;
    exp_wr = CNT_EN ? wr_done : 0;
    checks++;
    if (rd_err_cnt !== 16'(exp_rd) || wr_err_cnt !== 16'(exp_wr)) begin
      errors++;
      $display("FAIL err_counters got rd=%0d wr=%0d exp rd=%0d wr=%0d", rd_err_cnt, wr_err_cnt, exp_rd, exp_wr);
    end
  endtask

  task automatic test_reset_mid_read();
    ARID = 5'h15; ARLEN = 4'd3; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    RREADY = 1'b1;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (RVALID !== 1'b1 || RLAST !== 1'b0 || RID !== 5'h15) begin
        errors++;
        $display("FAIL mid_read_beat beat=%0d got rv=%b rlast=%b rid=%h exp 1 0 15", b, RVALID, RLAST, RID);
      end
      tick();
    end
    ARESETn = 1'b0;
    RREADY = 1'b0;
    #1;
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b0 || RLAST !== 1'b0 || RID !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset_async got rv=%b arr=%b rlast=%b rid=%h exp 0 0 0 00", RVALID, ARREADY, RLAST, RID);
    end
    rd_done = 0;
    wr_done = 0;
    test_counters();
    tick();
    ARESETn = 1'b1;
    #1;
    checks++;
    if (ARREADY !== 1'b0 || RVALID !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release got arr=%b rv=%b exp 0 0", ARREADY, RVALID);
    end
    tick();
    checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready got arr=%b rv=%b exp 1 0", ARREADY, RVALID);
    end
    $display("reset mid-read after 2 of 4 beats");
    run_read(5'h04, 4'd1, 0);
    test_counters();
  endtask

  initial begin
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    test_reset();
    test_read_burst();
    test_read_stall();
    test_write();
    test_w_before_aw();
    test_counters();
    test_random();
    test_counters();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xbar_default_slave.md
XBAR_DEFAULT_SLAVE -- requirements
Module: xbar_default_slave

Interface
REQ-001 Parameters SHALL be:
- IDS_WIDTH, default 5, extended ID width (master number + ID).
- ADDR_WIDTH, default 32, address width.
- LEN_WIDTH, default 4, burst length width.
- SIZE_WIDTH, default 3, burst size width.
- DATA_WIDTH, default 32, data width.
- STRB_WIDTH, default 4, write strobe width.

REQ-002 Ports SHALL be:
- ACLK  in  1  sole clock.
- ARESETn  in  1  reset, asynchronous, active-low.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  IDS/ADDR/LEN/SIZE/2/1  read address; ARREADY out 1.
- RID/RDATA/RRESP/RLAST/RVALID  out  IDS/DATA/2/1/1  read data; RREADY in 1.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  IDS/ADDR/LEN/SIZE/2/1  write address; AWREADY out 1.
- WDATA/WSTRB/WLAST/WVALID  in  DATA/STRB/1/1  write data; WREADY out 1.
- BID/BRESP/BVALID  out  IDS/2/1  write response; BREADY in 1.
- rd_err_cnt, wr_err_cnt  out  16 each  completed-transaction counters.

Function
REQ-003 The block SHALL be the AXI responder for unmapped addresses: it completes every transaction with RESP = DECERR (2'b11) and never stores data.
REQ-004 Read FSM states SHALL be R_IDLE and R_DATA. ARREADY = 1 only in R_IDLE with rdy_en = 1.
REQ-005 An AR handshake SHALL latch ARID and ARLEN, clear the beat counter and enter R_DATA. The first R beat is valid in the next cycle.
REQ-006 In R_DATA the block SHALL drive:
- RVALID = 1, RID = latched ID, RDATA = 0, RRESP = 2'b11;
- RLAST = 1 exactly when beat counter == latched ARLEN.
REQ-007 An R handshake with RLAST = 0 SHALL increment the beat counter (LEN_WIDTH bits, no wrap possible). With RLAST = 1 the FSM SHALL return to R_IDLE. ARREADY therefore rises one cycle after the last beat; there is no same-cycle AR acceptance.
REQ-008 RVALID, once asserted, SHALL stay high with stable payload until RREADY.
REQ-009 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP. AWREADY = 1 only in W_IDLE with rdy_en = 1.
REQ-010 An AW handshake SHALL latch AWID and enter W_DATA. WREADY = 1 only in W_DATA, so W beats arriving before their AW stall.
REQ-011 W beats SHALL be discarded. A W handshake with WLAST = 1 SHALL enter W_RESP; burst termination is decided by WLAST only, and AWLEN is ignored.
REQ-012 In W_RESP the block SHALL drive BVALID = 1, BID = latched ID, BRESP = 2'b11. A B handshake SHALL return the FSM to W_IDLE.
REQ-013 The read and write FSMs SHALL be independent. Simultaneous AR and AW handshakes SHALL both be accepted in the same cycle.
REQ-014 At most one read and one write SHALL be outstanding at any time.

Reset
REQ-015 ARESETn low SHALL asynchronously force:
- both FSMs to idle, counters to 0, rdy_en = 0;
- ARREADY = AWREADY = WREADY = RVALID = BVALID = 0;
- RID = BID = 0, RLAST = 0.
REQ-016 rdy_en SHALL set on the first ACLK edge after ARESETn deasserts.
REQ-017 Reset during a burst SHALL abandon it, with no further beat or response issued.

Configuration
REQ-018 With DEFAULT_SLAVE_ERR_CNT_EN defined:
- rd_err_cnt SHALL increment on each R handshake with RLAST = 1;
- wr_err_cnt SHALL increment on each B handshake;
- both counters saturate at 16'hFFFF.
REQ-019 Without DEFAULT_SLAVE_ERR_CNT_EN, both ports SHALL be tied to 0 and no counter logic is built.

Structure
REQ-020 The shared package xbar_pkg SHALL hold the RESP_OKAY, RESP_EXOKAY, RESP_SLVERR and RESP_DECERR constants and the rd_state_t and wr_state_t enums.
REQ-021 Sub-module sat_counter (16-bit, increment enable, saturating) SHALL be instantiated twice, only under the macro.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- AR ID=5'h13, LEN=3, RREADY=1 -> 4 beats on consecutive cycles, RID=13, RRESP=3, RDATA=0, RLAST on beat 4 only; ARREADY high the following cycle.
- AR LEN=0, RREADY low 5 cycles -> single beat held stable 5 cycles, RLAST=1, completes on the RREADY cycle.
- AW ID=5'h02, then 2 W beats with WLAST on the 2nd, BREADY=1 -> BVALID the cycle after WLAST, BID=02, BRESP=3.
- W beat presented before AW -> WREADY=0 until the AW handshake; AR and AW in the same cycle -> both accepted.
- ARESETn pulsed mid-read after beat 2 of 4 -> RVALID=0 immediately, ARREADY=0 in the first cycle after release, 1 from the next; with the macro defined, counters=0 after reset and rd_err_cnt=1 after one full read.
